// File: rtl/eth_mdio_master.sv
// Clause-22 MDIO management master.
// Each accepted command is sent as one 64-bit management frame, MSB first,
// with MDC generated by a programmable half-period divider. Reads return the
// 16 data bits sampled on MDC rising edges, plus a turnaround error flag.
//
// state  | meaning
// IDLE   | waiting for a command; cmd_ready high
// SHIFT  | serialising the 64-bit frame, one bit per MDC period
// DONE   | one-cycle completion; rsp_valid high, pads released
module eth_mdio_master #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic        msoc_clk,
    input  logic        rst_int,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phyad,
    input  logic [4:0]  cmd_regad,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_ta_err,
    output logic        busy,
    input  logic        phy_mdio_i,
    output logic        phy_mdio_o,
    output logic        phy_mdio_oe,
    output logic        phy_mdc
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

    state_e      state_q,     state_d;
    logic [7:0]  div_cnt_q,   div_cnt_d;
    logic [5:0]  bit_cnt_q,   bit_cnt_d;
    logic [63:0] tx_shift_q,  tx_shift_d;
    logic        is_write_q,  is_write_d;
    logic        mdc_q,       mdc_d;
    logic        mdio_o_q,    mdio_o_d;
    logic        mdio_oe_q,   mdio_oe_d;
    logic [15:0] rx_shift_q,  rx_shift_d;
    logic        ta_bad_q,    ta_bad_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_ta_err_q, rsp_ta_err_d;

    logic [63:0] frame;
    logic        oe_next;

    // Frame image built from the live command fields; only captured on accept.
    // Read frames carry zeros after REGAD since the pad is released there.
    assign frame = {32'hFFFF_FFFF, 2'b01,
                    cmd_write ? 2'b01 : 2'b10,
                    cmd_phyad, cmd_regad,
                    cmd_write ? 2'b10 : 2'b00,
                    cmd_write ? cmd_wdata : 16'h0000};

    // A read keeps driving only up to and including REGAD (bit 45).
    assign oe_next = is_write_q | (bit_cnt_q < 6'd45);

    // State and datapath registers.
    always_ff @(posedge msoc_clk or posedge rst_int) begin
        if (rst_int) begin
            state_q      <= ST_IDLE;
            div_cnt_q    <= 8'd0;
            bit_cnt_q    <= 6'd0;
            tx_shift_q   <= 64'd0;
            is_write_q   <= 1'b0;
            mdc_q        <= 1'b0;
            mdio_o_q     <= 1'b0;
            mdio_oe_q    <= 1'b0;
            rx_shift_q   <= 16'd0;
            ta_bad_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 16'd0;
            rsp_ta_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_shift_q   <= tx_shift_d;
            is_write_q   <= is_write_d;
            mdc_q        <= mdc_d;
            mdio_o_q     <= mdio_o_d;
            mdio_oe_q    <= mdio_oe_d;
            rx_shift_q   <= rx_shift_d;
            ta_bad_q     <= ta_bad_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_ta_err_q <= rsp_ta_err_d;
        end
    end

    // Next-state, MDC divider, bit sequencing and read sampling.
    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        tx_shift_d   = tx_shift_q;
        is_write_d   = is_write_q;
        mdc_d        = mdc_q;
        mdio_o_d     = mdio_o_q;
        mdio_oe_d    = mdio_oe_q;
        rx_shift_d   = rx_shift_q;
        ta_bad_d     = ta_bad_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_ta_err_d = rsp_ta_err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d    = ST_SHIFT;
                    tx_shift_d = frame;
                    is_write_d = cmd_write;
                    div_cnt_d  = DIV_RELOAD;
                    bit_cnt_d  = 6'd0;
                    mdc_d      = 1'b0;
                    mdio_o_d   = frame[63];
                    mdio_oe_d  = 1'b1;
                    rx_shift_d = 16'd0;
                    ta_bad_d   = 1'b0;
                end
            end

            ST_SHIFT: begin
                if (div_cnt_q != 8'd0) begin
                    div_cnt_d = div_cnt_q - 8'd1;
                end else begin
                    div_cnt_d = DIV_RELOAD;
                    if (!mdc_q) begin
                        // Rising edge: the PHY's bit is sampled here.
                        mdc_d = 1'b1;
                        if (!is_write_q) begin
                            if (bit_cnt_q == 6'd47) begin
                                ta_bad_d = phy_mdio_i;
                            end
                            if (bit_cnt_q >= 6'd48) begin
                                rx_shift_d = {rx_shift_q[14:0], phy_mdio_i};
                            end
                        end
                    end else begin
                        // Falling edge: start of the next bit's low phase.
                        mdc_d = 1'b0;
                        if (bit_cnt_q == 6'd63) begin
                            state_d     = ST_DONE;
                            mdio_o_d    = 1'b0;
                            mdio_oe_d   = 1'b0;
                            rsp_valid_d = 1'b1;
                            if (is_write_q) begin
                                rsp_ta_err_d = 1'b0;
                            end else begin
                                rsp_rdata_d  = rx_shift_q;
                                rsp_ta_err_d = ta_bad_q;
                            end
                        end else begin
                            bit_cnt_d  = bit_cnt_q + 6'd1;
                            tx_shift_d = {tx_shift_q[62:0], 1'b0};
                            mdio_oe_d  = oe_next;
                            mdio_o_d   = tx_shift_q[62] & oe_next;
                        end
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = ~cmd_ready | rsp_valid_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_ta_err  = rsp_ta_err_q;
    assign phy_mdc     = mdc_q;
    assign phy_mdio_o  = mdio_o_q;
    assign phy_mdio_oe = mdio_oe_q;

endmodule

// File: tb/tb_eth_mdio_master.sv
// Testbench for eth_mdio_master: three instances with MDC dividers 2, 4, 255.
// A PHY model drives MDIO per bit slot; expected frames, timing and responses
// come from the frame format and cycle rules of the management interface.
module tb_eth_mdio_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid  [3];
    logic        cmd_ready  [3];
    logic        cmd_write  [3];
    logic [4:0]  cmd_phyad  [3];
    logic [4:0]  cmd_regad  [3];
    logic [15:0] cmd_wdata  [3];
    logic        rsp_valid  [3];
    logic [15:0] rsp_rdata  [3];
    logic        rsp_ta_err [3];
    logic        busy       [3];
    logic        mdio_i     [3];
    logic        mdio_o     [3];
    logic        mdio_oe    [3];
    logic        mdc        [3];

    int n_pass  = 0;
    int n_total = 0;
    logic [15:0] exp_rdata [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned DIV = (g == 0) ? 2 : ((g == 1) ? 4 : 255);
        eth_mdio_master #(.CLK_DIV(DIV)) u_dut (
            .msoc_clk   (clk),
            .rst_int    (rst),
            .cmd_valid  (cmd_valid[g]),
            .cmd_ready  (cmd_ready[g]),
            .cmd_write  (cmd_write[g]),
            .cmd_phyad  (cmd_phyad[g]),
            .cmd_regad  (cmd_regad[g]),
            .cmd_wdata  (cmd_wdata[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_rdata  (rsp_rdata[g]),
            .rsp_ta_err (rsp_ta_err[g]),
            .busy       (busy[g]),
            .phy_mdio_i (mdio_i[g]),
            .phy_mdio_o (mdio_o[g]),
            .phy_mdio_oe(mdio_oe[g]),
            .phy_mdc    (mdc[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int div_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 4 : 255);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Issue one command on instance i (called #1 after a clock edge, in the
    // intended accept cycle) and follow it to the first IDLE cycle.
    task automatic run_frame(input int i, input bit wr, input logic [4:0] pa,
                             input logic [4:0] ra, input logic [15:0] wd,
                             input bit ta_bit, input logic [15:0] phy_data,
                             input bit hold_valid);
        int div;
        int last;
        int b;
        int rises;
        int bad_mdc;
        int bad_chg;
        int bad_hs;
        int first_rise;
        int second_rise;
        int first_fall;
        int oe_drop;
        bit exp_mdc;
        bit exp_ta;
        logic [31:0] r;
        logic [63:0] exp_frame;
        logic [63:0] exp_oe;
        logic [63:0] got_frame;
        logic [63:0] got_oe;
        logic prev_o;
        logic prev_oe;
        logic prev_mdc;

        div = div_of(i);
        last = 1 + 128 * div;
        rises = 0; bad_mdc = 0; bad_chg = 0; bad_hs = 0;
        first_rise = -1; second_rise = -1; first_fall = -1; oe_drop = -1;
        got_frame = '0; got_oe = '0;
        exp_frame = {32'hFFFF_FFFF, 2'b01, wr ? 2'b01 : 2'b10, pa, ra,
                     wr ? 2'b10 : 2'b00, wr ? wd : 16'h0000};
        exp_oe = wr ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFC_0000;
        if (!wr) exp_rdata[i] = phy_data;
        exp_ta = !wr && ta_bit;

        cmd_valid[i] = 1'b1;
        cmd_write[i] = wr;
        cmd_phyad[i] = pa;
        cmd_regad[i] = ra;
        cmd_wdata[i] = wd;
        chk("accept_ready", 64'(cmd_ready[i]), 64'(1));
        prev_o = mdio_o[i]; prev_oe = mdio_oe[i]; prev_mdc = mdc[i];

        for (int k = 1; k <= last + 1; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                r = $urandom;
                cmd_valid[i] = hold_valid;
                cmd_write[i] = r[0];
                cmd_phyad[i] = r[5:1];
                cmd_regad[i] = r[10:6];
                cmd_wdata[i] = r[26:11];
            end
            if (k <= last) begin
                b = (k - 1) / (2 * div);
                if (wr || b < 47) mdio_i[i] = 1'b1;
                else if (b == 47) mdio_i[i] = ta_bit;
                else mdio_i[i] = phy_data[63 - b];

                exp_mdc = (((k - 1) / div) % 2) == 1;
                if (mdc[i] !== exp_mdc) bad_mdc++;
                if (cmd_ready[i] !== 1'b0 || busy[i] !== 1'b1) bad_hs++;
                if (rsp_valid[i] !== (k == last)) bad_hs++;
                if ((mdio_o[i] !== prev_o || mdio_oe[i] !== prev_oe) &&
                    ((k - 1) % (2 * div) != 0)) bad_chg++;
                if (mdc[i] === 1'b1 && prev_mdc === 1'b0) begin
                    got_frame = {got_frame[62:0], mdio_o[i]};
                    got_oe = {got_oe[62:0], mdio_oe[i]};
                    rises++;
                    if (first_rise < 0) first_rise = k;
                    else if (second_rise < 0) second_rise = k;
                end
                if (mdc[i] === 1'b0 && prev_mdc === 1'b1 && first_fall < 0) first_fall = k;
                if (prev_oe === 1'b1 && mdio_oe[i] === 1'b0 && oe_drop < 0) oe_drop = k;
                prev_o = mdio_o[i]; prev_oe = mdio_oe[i]; prev_mdc = mdc[i];
                if (k == last) begin
                    chk("done_oe", 64'(mdio_oe[i]), 64'(0));
                    chk("done_o", 64'(mdio_o[i]), 64'(0));
                    chk("done_mdc", 64'(mdc[i]), 64'(0));
                    chk("done_rdata", 64'(rsp_rdata[i]), 64'(exp_rdata[i]));
                    chk("done_ta_err", 64'(rsp_ta_err[i]), 64'(exp_ta));
                end
            end else begin
                chk("idle_ready", 64'(cmd_ready[i]), 64'(1));
                chk("idle_busy", 64'(busy[i]), 64'(0));
                chk("idle_rsp_valid", 64'(rsp_valid[i]), 64'(0));
            end
        end
        chk("frame_bits", got_frame, exp_frame);
        chk("frame_oe", got_oe, exp_oe);
        chk("mdc_rises", 64'(rises), 64'(64));
        chk("mdc_wave", 64'(bad_mdc), 64'(0));
        chk("pad_change_timing", 64'(bad_chg), 64'(0));
        chk("handshake_timing", 64'(bad_hs), 64'(0));
        chk("first_rise", 64'(first_rise), 64'(1 + div));
        chk("mdc_period", 64'(second_rise - first_rise), 64'(2 * div));
        chk("mdc_high", 64'(first_fall - first_rise), 64'(div));
        chk("oe_drop", 64'(oe_drop), 64'(wr ? last : 1 + 2 * div * 46));
    endtask

    task automatic run_random(input int i);
        logic [31:0] r1;
        logic [31:0] r2;
        r1 = $urandom;
        r2 = $urandom;
        run_frame(i, r1[0], r1[5:1], r1[10:6], r1[26:11], r1[28:27] == 2'b11,
                  r2[15:0], 1'b0);
    endtask

    // Reset pulsed during the high phase of b40 of a write on instance 0.
    task automatic reset_mid_frame();
        int rv_seen;
        rv_seen = 0;
        cmd_valid[0] = 1'b1;
        cmd_write[0] = 1'b1;
        cmd_phyad[0] = 5'h15;
        cmd_regad[0] = 5'h0A;
        cmd_wdata[0] = 16'hBEEF;
        chk("rst_accept_ready", 64'(cmd_ready[0]), 64'(1));
        for (int k = 1; k <= 163; k++) begin
            @(posedge clk); #1;
            if (k == 1) cmd_valid[0] = 1'b0;
        end
        chk("pre_rst_mdc", 64'(mdc[0]), 64'(1));
        chk("pre_rst_o", 64'(mdio_o[0]), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk("rst_mdc", 64'(mdc[0]), 64'(0));
        chk("rst_oe", 64'(mdio_oe[0]), 64'(0));
        chk("rst_o", 64'(mdio_o[0]), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid[0]), 64'(0));
        for (int j = 0; j < 3; j++) exp_rdata[j] = 16'h0000;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (rsp_valid[0] !== 1'b0) rv_seen++;
        end
        chk("no_rsp_after_rst", 64'(rv_seen), 64'(0));
        chk("rst_rdata", 64'(rsp_rdata[0]), 64'(0));
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_valid[i] = 1'b0; cmd_write[i] = 1'b0;
            cmd_phyad[i] = '0; cmd_regad[i] = '0; cmd_wdata[i] = '0;
            mdio_i[i] = 1'b1;
            exp_rdata[i] = 16'h0000;
        end
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_ready", 64'(cmd_ready[i]), 64'(1));
            chk("reset_outputs", 64'({rsp_valid[i], rsp_ta_err[i], busy[i],
                                      mdc[i], mdio_o[i], mdio_oe[i]}), 64'(0));
            chk("reset_rdata", 64'(rsp_rdata[i]), 64'(0));
        end

        run_frame(0, 1'b1, 5'h01, 5'h00, 16'h1140, 1'b0, 16'h0000, 1'b0);
        run_frame(1, 1'b0, 5'h03, 5'h02, 16'h0000, 1'b0, 16'h0141, 1'b0);
        run_frame(1, 1'b0, 5'h07, 5'h1F, 16'h0000, 1'b1, 16'hFFFF, 1'b0);
        run_frame(1, 1'b1, 5'h07, 5'h04, 16'h01E1, 1'b0, 16'h0000, 1'b0);

        // cmd_valid stays high across both commands.
        run_frame(0, 1'b1, 5'h1E, 5'h11, 16'hA5C3, 1'b0, 16'h0000, 1'b1);
        run_frame(0, 1'b0, 5'h09, 5'h05, 16'h0000, 1'b0, 16'h7E42, 1'b0);

        for (int n = 0; n < 6; n++) run_random(n % 2);

        reset_mid_frame();
        run_frame(0, 1'b1, 5'h15, 5'h0A, 16'hBEEF, 1'b0, 16'h0000, 1'b0);
        run_random(0);

        run_frame(2, 1'b0, 5'h1C, 5'h13, 16'h0000, 1'b0, 16'($urandom), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
